// File: rtl/bp_fe_fetch_buffer.sv
// bp_fe_fetch_buffer: credit-managed instruction buffer behind the front-end I$.
// Optional BP_FE_FETCH_BUFFER_BYPASS_EN forwards an I$ return to the head while empty.
module bp_fe_fetch_buffer #(
    parameter int els_p          = 16,
    parameter int instr_width_p  = 32,
    parameter int vaddr_width_p  = 39,
    parameter int max_inflight_p = 2
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   fetch_v_i,
    output logic                                   fetch_ready_o,
    input  logic                                   data_v_i,
    input  logic [instr_width_p-1:0]               data_i,
    input  logic [vaddr_width_p-1:0]               vaddr_i,
    input  logic                                   drop_i,
    input  logic                                   flush_i,
    output logic                                   v_o,
    output logic [vaddr_width_p+instr_width_p-1:0] data_o,
    input  logic                                   yumi_i,
    output logic [$clog2(els_p+1)-1:0]             count_o,
    output logic                                   overflow_o
);

    localparam int ptr_w   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w   = $clog2(els_p + 1);
    localparam int inf_w   = $clog2(max_inflight_p + 1);
    localparam int entry_w = vaddr_width_p + instr_width_p;

    logic [entry_w-1:0] mem [els_p];
    logic [ptr_w-1:0]   rptr, wptr;
    logic [cnt_w-1:0]   count;
    logic [inf_w-1:0]   inflight, discard, discard_flush;
    logic               overflow;

    logic ret, absorb, live, stray, accept, enq_valid, deq, full;
    logic bypass, bypass_take, write, drop_full;
    int   stale_sum;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (int'(p) == els_p - 1) ? '0 : p + 1'b1;
    endfunction

    assign fetch_ready_o = ~reset_i & ~flush_i
                         & ((int'(count) + int'(inflight)) < els_p)
                         & (int'(inflight) < max_inflight_p);

    // Stale returns (discard > 0) are absorbed first; a return with nothing outstanding is stray.
    assign ret    = data_v_i | drop_i;
    assign absorb = ret & (discard != '0);
    assign live   = ret & (discard == '0) & (inflight != '0);
    assign stray  = ret & (discard == '0) & (inflight == '0);
    assign accept = fetch_v_i & fetch_ready_o;

    assign enq_valid = data_v_i & live & ~flush_i;
    assign deq       = yumi_i & (count != '0) & ~flush_i;
    assign full      = (count == cnt_w'(els_p));

`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
    assign bypass = enq_valid & (count == '0);
`else
    assign bypass = 1'b0;
`endif
    assign bypass_take = bypass & yumi_i;

    assign write     = enq_valid & ~bypass_take & (~full | deq);
    assign drop_full = enq_valid & full & ~deq;

    assign v_o        = (count != '0) | bypass;
    assign data_o     = bypass ? {vaddr_i, data_i} : mem[rptr];
    assign count_o    = count;
    assign overflow_o = overflow;

    always_comb begin
        stale_sum     = int'(discard) + int'(inflight) - int'(absorb | live);
        discard_flush = (stale_sum > max_inflight_p) ? inf_w'(max_inflight_p) : inf_w'(stale_sum);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            overflow <= 1'b0;
        end else begin
            if (stray | drop_full)
                overflow <= 1'b1;
            if (flush_i) begin
                count    <= '0;
                rptr     <= wptr;
                inflight <= '0;
                discard  <= discard_flush;
            end else begin
                count    <= count + cnt_w'(write) - cnt_w'(deq);
                inflight <= inflight + inf_w'(accept) - inf_w'(live);
                discard  <= discard - inf_w'(absorb);
                if (write)
                    wptr <= ptr_inc(wptr);
                if (deq)
                    rptr <= ptr_inc(rptr);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (write)
            mem[wptr] <= {vaddr_i, data_i};
    end

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Self-checking bench for bp_fe_fetch_buffer: queue-level reference model plus directed pins.
module tb_bp_fe_fetch_buffer;
    localparam int ELS = 16;
    localparam int IW  = 32;
    localparam int VW  = 39;
    localparam int MI  = 2;
    localparam int CW  = $clog2(ELS + 1);
`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic reset_i, fetch_v_i, data_v_i, drop_i, flush_i, yumi_i;
    logic [IW-1:0]    data_i;
    logic [VW-1:0]    vaddr_i;
    logic             fetch_ready_o, v_o, overflow_o;
    logic [VW+IW-1:0] data_o;
    logic [CW-1:0]    count_o;

    always #5 clk_i = ~clk_i;

    bp_fe_fetch_buffer #(
        .els_p(ELS), .instr_width_p(IW), .vaddr_width_p(VW), .max_inflight_p(MI)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .fetch_v_i(fetch_v_i), .fetch_ready_o(fetch_ready_o),
        .data_v_i(data_v_i), .data_i(data_i), .vaddr_i(vaddr_i), .drop_i(drop_i),
        .flush_i(flush_i), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
        .count_o(count_o), .overflow_o(overflow_o)
    );

    // Reference model: entries in a queue, outstanding/stale fetches as plain integers.
    logic [VW+IW-1:0] mq[$];
    int m_inf, m_disc;
    bit m_ovf;

    // Environment I$: accepted fetches return in order after 1-2 cycles.
    logic [VW-1:0] pipe_va[$];
    int            pipe_due[$];
    int            cyc;
    logic [VW-1:0] next_pc;

    int n_assert, n_fail;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_and_step();
        bit ready_e, ret, live, bypass, v_e;
        if (reset_i) begin
            mq.delete();
            m_inf = 0; m_disc = 0; m_ovf = 0;
            check("rst_count", count_o, 0);
            check("rst_v", v_o, 0);
            check("rst_ready", fetch_ready_o, 0);
            check("rst_ovf", overflow_o, 0);
            return;
        end
        ready_e = !flush_i && (mq.size() + m_inf < ELS) && (m_inf < MI);
        ret     = data_v_i || drop_i;
        live    = ret && m_disc == 0 && m_inf > 0;
        bypass  = BYP && live && data_v_i && !flush_i && mq.size() == 0;
        v_e     = (mq.size() != 0) || bypass;
        check("ready", fetch_ready_o, ready_e);
        check("v", v_o, v_e);
        check("count", count_o, mq.size());
        check("overflow", overflow_o, m_ovf);
        if (v_e)
            check("data", data_o, bypass ? {vaddr_i, data_i} : mq[0]);
        if (ret) begin
            if (m_disc > 0) m_disc--;
            else if (m_inf > 0) m_inf--;
            else m_ovf = 1;
        end
        if (flush_i) begin
            mq.delete();
            m_disc = (m_disc + m_inf > MI) ? MI : m_disc + m_inf;
            m_inf  = 0;
        end else begin
            if (yumi_i && mq.size() > 0)
                void'(mq.pop_front());
            if (live && data_v_i && !(bypass && yumi_i)) begin
                if (mq.size() < ELS) mq.push_back({vaddr_i, data_i});
                else m_ovf = 1;
            end
            if (fetch_v_i && ready_e) m_inf++;
        end
    endtask

    task automatic idle();
        fetch_v_i = 0; data_v_i = 0; drop_i = 0; flush_i = 0; yumi_i = 0;
        data_i = '0; vaddr_i = '0;
    endtask

    task automatic finish_cycle(output bit acc);
        @(negedge clk_i);
        compare_and_step();
        acc = fetch_v_i && fetch_ready_o;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        bit acc;
        finish_cycle(acc);
    endtask

    task automatic drive(input bit want_fetch, input int yumi_pct, input int drop_pct,
                         input int flush_pct, output bit acc);
        int due;
        idle();
        fetch_v_i = want_fetch && (pipe_va.size() < MI);
        flush_i   = ($urandom_range(99) < flush_pct);
        if (pipe_va.size() > 0 && pipe_due[0] <= cyc) begin
            vaddr_i = pipe_va.pop_front();
            void'(pipe_due.pop_front());
            data_i  = $urandom;
            if ($urandom_range(99) < drop_pct) drop_i = 1;
            else data_v_i = 1;
        end
        #1;
        if (v_o && $urandom_range(99) < yumi_pct) yumi_i = 1;
        finish_cycle(acc);
        if (acc) begin
            due = cyc + $urandom_range(1);
            if (pipe_due.size() > 0 && due <= pipe_due[pipe_due.size()-1])
                due = pipe_due[pipe_due.size()-1] + 1;
            pipe_va.push_back(next_pc);
            pipe_due.push_back(due);
            next_pc = next_pc + VW'(4);
        end
    endtask

    initial begin
        bit acc;
        int accepted;
        logic [VW-1:0] pc0;
        int yp[3] = '{40, 90, 10};
        n_assert = 0; n_fail = 0; cyc = 0;
        next_pc = VW'(39'h40_0000_0000 >> 2);
        reset_i = 1;
        idle();
        @(posedge clk_i); #1;
        cycle(); cycle();
        reset_i = 0;
        #1;
        check("pin_ready_after_reset", fetch_ready_o, 1);
        check("pin_empty_after_reset", v_o, 0);

        // Randomized traffic with flushes and drops, then drain everything.
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 400; i++)
                drive($urandom_range(99) < 80, yp[p], 15, 3, acc);
        for (int i = 0; i < 100 && (pipe_va.size() > 0 || count_o != 0); i++)
            drive(0, 100, 0, 0, acc);
        check("pin_drained", count_o, 0);
        check("pin_no_overflow", overflow_o, 0);

        // Drop: first fetch drops, second returns 0x13.
        idle(); fetch_v_i = 1; cycle();
        idle(); fetch_v_i = 1; cycle();
        idle(); drop_i = 1; cycle();
        idle(); data_v_i = 1; data_i = 32'h0000_0013; vaddr_i = VW'(39'h1004); cycle();
        idle();
        check("pin_drop_count", count_o, 1);
        check("pin_drop_instr", data_o[IW-1:0], 32'h0000_0013);
        check("pin_drop_ready", fetch_ready_o, 1);
        yumi_i = 1; cycle(); idle();

        // Bypass: empty buffer, return and take in the same cycle.
        fetch_v_i = 1; cycle();
        idle(); data_v_i = 1; data_i = 32'hCAFE_0001; vaddr_i = VW'(39'h2000);
        #1;
        check("pin_bypass_v", v_o, BYP);
        yumi_i = v_o;
        cycle(); idle();
        check("pin_bypass_count", count_o, BYP ? 0 : 1);
        if (v_o) begin yumi_i = 1; cycle(); idle(); end

        // Streaming: exactly els_p fetches fit with no consumer.
        pc0 = next_pc;
        accepted = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1, 0, 0, 0, acc);
            if (acc) accepted++;
        end
        idle();
        check("pin_stream_accepted", accepted, ELS);
        check("pin_stream_count", count_o, ELS);
        check("pin_stream_ready", fetch_ready_o, 0);
        check("pin_stream_ovf", overflow_o, 0);

        // Return with nothing outstanding while full: dropped, sticky overflow.
        data_v_i = 1; data_i = 32'hDEAD_BEEF; vaddr_i = VW'(39'h7777); cycle(); idle();
        check("pin_full_ovf", overflow_o, 1);
        check("pin_full_count", count_o, ELS);
        cycle();
        check("pin_ovf_sticky", overflow_o, 1);

        for (int i = 0; i < ELS; i++) begin
            idle(); yumi_i = 1;
            #1;
            check("pin_drain_order", data_o[VW+IW-1:IW], pc0 + VW'(4 * i));
            cycle();
        end
        idle();
        check("pin_drain_empty", count_o, 0);

        // Flush with count=3, inflight=2: two stale returns discarded, third enqueued.
        for (int i = 0; i < 5; i++) begin
            idle(); fetch_v_i = 1;
            if (i > 0 && i < 4) begin data_v_i = 1; vaddr_i = VW'(39'h3000 + 4 * i); end
            cycle();
        end
        idle();
        check("pin_preflush_count", count_o, 3);
        flush_i = 1; cycle(); idle();
        check("pin_flush_count", count_o, 0);
        check("pin_flush_v", v_o, 0);
        fetch_v_i = 1; data_v_i = 1; vaddr_i = VW'(39'h5000); cycle(); idle();
        data_v_i = 1; vaddr_i = VW'(39'h5004); cycle(); idle();
        check("pin_discard_count", count_o, 0);
        data_v_i = 1; data_i = 32'h1234_5678; vaddr_i = VW'(39'hBEEF); cycle(); idle();
        check("pin_post_flush_count", count_o, 1);
        check("pin_post_flush_vaddr", data_o[VW+IW-1:IW], VW'(39'hBEEF));
        yumi_i = 1; cycle(); idle();

        // Reset mid-operation with count=5, inflight=2, then two late returns.
        for (int i = 0; i < 7; i++) begin
            idle(); fetch_v_i = 1;
            if (i >= 1 && i <= 5) begin data_v_i = 1; vaddr_i = VW'(39'h6000 + 4 * i); end
            cycle();
        end
        idle();
        check("pin_prereset_count", count_o, 5);
        reset_i = 1;
        #1;
        check("pin_async_count", count_o, 0);
        check("pin_async_v", v_o, 0);
        check("pin_async_ready", fetch_ready_o, 0);
        cycle();
        reset_i = 0;
        cycle();
        data_v_i = 1; cycle(); cycle(); idle();
        check("pin_late_ovf", overflow_o, 1);
        check("pin_late_count", count_o, 0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
